// File: rtl/bottling_sequencer.sv
// bottling_sequencer: run controller for the bottling line.
// Latches settings, times pill pulses and sequences bottle changes.
module bottling_sequencer #(
  parameter int TICK_DIV     = 25000000,
  parameter int BOTTLE_DELAY = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic [7:0] bottle_setting,
  input  logic [7:0] pill_setting,
  input  logic       finished,
  input  logic [7:0] pill,
  output logic [7:0] bottle_setting_q,
  output logic [7:0] pill_setting_q,
  output logic       counter_en,
  output logic       pill_pulse,
  output logic       counter_clr,
  output logic       hopper_open,
  output logic       conveyor,
  output logic [2:0] state,
  output logic       error
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW =
    (BOTTLE_DELAY > 1) ? $clog2(BOTTLE_DELAY) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(BOTTLE_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    CHANGE = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t        cur;
  state_t        nxt;
  logic [TW-1:0] tick;
  logic [TW-1:0] tick_n;
  logic [DW-1:0] delay;
  logic [DW-1:0] delay_n;
  logic          pend;
  logic          pend_n;
  logic          clr_n;
  logic [7:0]    bq_n;
  logic [7:0]    pq_n;
  logic          set_ok;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) &&
           (v != 8'h00);
  endfunction

  assign set_ok = bcd_ok(bottle_setting) &&
                  bcd_ok(pill_setting);

  // pend marks a pulse whose counter result is not yet judged
  always_comb begin
    nxt     = cur;
    tick_n  = tick;
    delay_n = delay;
    pend_n  = pend;
    clr_n   = 1'b0;
    bq_n    = bottle_setting_q;
    pq_n    = pill_setting_q;
    if (stop && cur != IDLE) begin
      nxt     = IDLE;
      tick_n  = '0;
      delay_n = '0;
      pend_n  = 1'b0;
      clr_n   = 1'b1;
    end else begin
      unique case (cur)
        IDLE, DONE, ERROR: begin
          if (start) begin
            if (set_ok) begin
              nxt    = RUN;
              bq_n   = bottle_setting;
              pq_n   = pill_setting;
              clr_n  = 1'b1;
              tick_n = '0;
              pend_n = 1'b0;
            end else begin
              nxt = ERROR;
            end
          end
        end
        RUN: begin
          if (tick == TICK_LAST) begin
            tick_n = '0;
            pend_n = 1'b1;
          end else begin
            tick_n = tick + TW'(1);
          end
          if (pause) begin
            nxt = PAUSED;
          end else if (pend) begin
            pend_n = 1'b0;
            if (finished) begin
              nxt = DONE;
            end else if (pill == 8'h00) begin
              nxt     = CHANGE;
              delay_n = '0;
            end
          end
        end
        CHANGE: begin
          if (delay == DLY_LAST) begin
            nxt     = RUN;
            tick_n  = '0;
            delay_n = '0;
          end else begin
            delay_n = delay + DW'(1);
          end
        end
        PAUSED: begin
          if (pause) begin
            nxt    = RUN;
            pend_n = 1'b0;
            if (pend) begin
              if (finished) begin
                nxt = DONE;
              end else if (pill == 8'h00) begin
                nxt     = CHANGE;
                delay_n = '0;
              end
            end
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur              <= IDLE;
      tick             <= '0;
      delay            <= '0;
      pend             <= 1'b0;
      bottle_setting_q <= 8'h00;
      pill_setting_q   <= 8'h00;
      counter_en       <= 1'b0;
      pill_pulse       <= 1'b0;
      counter_clr      <= 1'b0;
      hopper_open      <= 1'b0;
      conveyor         <= 1'b0;
      error            <= 1'b0;
    end else begin
      cur              <= nxt;
      tick             <= tick_n;
      delay            <= delay_n;
      pend             <= pend_n;
      bottle_setting_q <= bq_n;
      pill_setting_q   <= pq_n;
      counter_en       <= (nxt == RUN) || (nxt == CHANGE) ||
                          (nxt == PAUSED) || (nxt == DONE);
      pill_pulse       <= (nxt == RUN) &&
                          (tick_n == TICK_LAST);
      counter_clr      <= clr_n;
      hopper_open      <= (nxt == RUN);
      conveyor         <= (nxt == CHANGE);
      error            <= (nxt == ERROR);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_bottling_sequencer.sv
// tb_bottling_sequencer: scoreboard bench with a counters model
// and a behavioural reference of the run controller.
module tb_bottling_sequencer;

  localparam int TD = 4;
  localparam int BD = 3;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_CHG  = 2;
  localparam int S_PAU  = 3;
  localparam int S_DONE = 4;
  localparam int S_ERR  = 5;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       pause;
  logic       stop;
  logic [7:0] bottle_setting;
  logic [7:0] pill_setting;
  logic       e_fin;
  logic [7:0] pill_w;
  logic [7:0] bottle_setting_q;
  logic [7:0] pill_setting_q;
  logic       counter_en;
  logic       pill_pulse;
  logic       counter_clr;
  logic       hopper_open;
  logic       conveyor;
  logic [2:0] state;
  logic       error;

  bottling_sequencer #(.TICK_DIV(TD), .BOTTLE_DELAY(BD)) dut (
    .clk(clk), .reset_n(reset_n),
    .start(start), .pause(pause), .stop(stop),
    .bottle_setting(bottle_setting),
    .pill_setting(pill_setting),
    .finished(e_fin), .pill(pill_w),
    .bottle_setting_q(bottle_setting_q),
    .pill_setting_q(pill_setting_q),
    .counter_en(counter_en), .pill_pulse(pill_pulse),
    .counter_clr(counter_clr), .hopper_open(hopper_open),
    .conveyor(conveyor), .state(state), .error(error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic bit ok(input logic [7:0] v);
    return v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v != 8'h00;
  endfunction

  // attached counters, driven by the DUT
  int e_pill;
  int e_bot;
  assign pill_w = to_bcd(e_pill);
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_pill <= 0; e_bot <= 0; e_fin <= 1'b0;
    end else if (counter_clr) begin
      e_pill <= 0; e_bot <= 0; e_fin <= 1'b0;
    end else if (counter_en && pill_pulse) begin
      if (e_pill + 1 == bcd2int(pill_setting_q)) begin
        e_pill <= 0;
        e_bot  <= e_bot + 1;
        if (e_bot + 1 == bcd2int(bottle_setting_q))
          e_fin <= 1'b1;
      end else begin
        e_pill <= e_pill + 1;
      end
    end
  end

  // reference model: run-cycle count and change countdown
  int         ms;
  int         m_run;
  int         m_chg;
  bit         m_eval;
  bit         m_clr;
  logic [7:0] mbq;
  logic [7:0] mpq;
  int         mc_pill;
  int         mc_bot;
  bit         mc_fin;

  task automatic model_reset();
    ms = S_IDLE; m_run = 0; m_chg = 0; m_eval = 0; m_clr = 0;
    mbq = 8'h00; mpq = 8'h00;
    mc_pill = 0; mc_bot = 0; mc_fin = 0;
  endtask

  function automatic bit pulse_now();
    return ms == S_RUN && (m_run % TD) == TD - 1;
  endfunction

  function automatic logic [24:0] m_out();
    logic [2:0] s;
    s = 3'(ms);
    return {s, ms >= S_RUN && ms <= S_DONE, pulse_now(),
            m_clr, ms == S_RUN, ms == S_CHG, ms == S_ERR,
            mbq, mpq};
  endfunction

  task automatic judge();
    m_eval = 0;
    if (mc_fin) ms = S_DONE;
    else if (mc_pill == 0) begin
      ms = S_CHG; m_chg = BD;
    end
  endtask

  task automatic model_step(input bit st, input bit pa,
                            input bit sp);
    bit p;
    bit ev;
    bit nclr;
    p = pulse_now();
    ev = m_eval;
    nclr = 0;
    if (sp && ms != S_IDLE) begin
      ms = S_IDLE; m_run = 0; m_chg = 0; m_eval = 0; nclr = 1;
    end else if (st && (ms == S_IDLE || ms == S_DONE ||
                        ms == S_ERR)) begin
      if (ok(bottle_setting) && ok(pill_setting)) begin
        mbq = bottle_setting; mpq = pill_setting;
        nclr = 1; ms = S_RUN; m_run = 0; m_eval = 0;
      end else begin
        ms = S_ERR;
      end
    end else if (ms == S_RUN) begin
      m_run++;
      if (p) m_eval = 1;
      if (pa) ms = S_PAU;
      else if (ev) judge();
    end else if (ms == S_CHG) begin
      m_chg--;
      if (m_chg == 0) begin
        ms = S_RUN; m_run = 0;
      end
    end else if (ms == S_PAU && pa) begin
      ms = S_RUN;
      if (m_eval) judge();
    end
    if (m_clr) begin
      mc_pill = 0; mc_bot = 0; mc_fin = 0;
    end else if (p) begin
      mc_pill++;
      if (mc_pill == bcd2int(mpq)) begin
        mc_pill = 0;
        mc_bot++;
        if (mc_bot == bcd2int(mbq)) mc_fin = 1;
      end
    end
    m_clr = nclr;
  endtask

  // scoreboard: bit 25 flags an expired wait
  logic [25:0] sb[$];
  string       phase;
  int          n_tests;
  int          n_fail;

  always @(negedge clk) begin
    logic [25:0] it;
    logic [24:0] act;
    act = {state, counter_en, pill_pulse, counter_clr,
           hopper_open, conveyor, error,
           bottle_setting_q, pill_setting_q};
    while (sb.size() != 0) begin
      it = sb.pop_front();
      n_tests++;
      if (it[25]) begin
        n_fail++;
        $display("FAIL %s: wait expired, actual state=%0d required event reached",
                 phase, state);
      end else if (act !== it[24:0]) begin
        n_fail++;
        $display("FAIL %s: outputs actual=%h required=%h",
                 phase, act, it[24:0]);
      end
    end
  end

  task automatic cyc(input bit st, input bit pa, input bit sp);
    start = st; pause = pa; stop = sp;
    sb.push_back({1'b0, m_out()});
    if (reset_n) model_step(st, pa, sp);
    @(posedge clk);
    #1;
    start = 0; pause = 0; stop = 0;
  endtask

  task automatic run_until(input int what, input int budget);
    int n;
    n = 0;
    while (ms != what && n < budget) begin
      cyc(0, 0, 0);
      n++;
    end
    if (ms != what) sb.push_back({1'b1, 25'h0});
  endtask

  task automatic run_until_pulse(input int budget);
    int n;
    n = 0;
    while (!pulse_now() && n < budget) begin
      cyc(0, 0, 0);
      n++;
    end
    if (!pulse_now()) sb.push_back({1'b1, 25'h0});
  endtask

  function automatic logic [7:0] pick_set();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'h0A;
    if (r == 2) return 8'hB2;
    return to_bcd($urandom_range(1, 3));
  endfunction

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; start = 0; pause = 0; stop = 0;
    bottle_setting = 8'h00; pill_setting = 8'h00;
    model_reset();
    phase = "reset";
    @(posedge clk);
    #1;
    repeat (3) cyc(0, 0, 0);
    reset_n = 1'b1;
    cyc(0, 1, 1);

    phase = "nominal";
    bottle_setting = 8'h02; pill_setting = 8'h03;
    cyc(1, 0, 0);
    bottle_setting = 8'h07;
    run_until(S_DONE, 100);
    repeat (3) cyc(0, 0, 0);

    phase = "invalid";
    bottle_setting = 8'h02; pill_setting = 8'h0A;
    cyc(1, 0, 0);
    repeat (6) cyc(0, 1, 0);
    pill_setting = 8'h05;
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);

    phase = "zero";
    cyc(0, 0, 1);
    bottle_setting = 8'h00;
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);

    phase = "pause";
    bottle_setting = 8'h02; pill_setting = 8'h05;
    cyc(1, 0, 0);
    run_until_pulse(20);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (10) cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (6) cyc(0, 0, 0);

    phase = "stop_change";
    run_until(S_CHG, 100);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    bottle_setting = 8'h01; pill_setting = 8'h02;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);

    phase = "start_stop";
    cyc(1, 0, 1);
    repeat (2) cyc(0, 0, 0);

    phase = "pause_on_pulse";
    bottle_setting = 8'h01; pill_setting = 8'h01;
    cyc(1, 0, 0);
    run_until_pulse(20);
    cyc(0, 1, 0);
    repeat (5) cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 0);

    phase = "async_reset";
    bottle_setting = 8'h03; pill_setting = 8'h03;
    cyc(1, 0, 0);
    repeat (6) cyc(0, 0, 0);
    reset_n = 1'b0;
    model_reset();
    repeat (3) cyc(0, 0, 0);
    reset_n = 1'b1;
    repeat (6) cyc(0, 0, 0);

    phase = "random";
    repeat (1500) begin
      if ($urandom_range(0, 9) == 0) bottle_setting = pick_set();
      if ($urandom_range(0, 9) == 0) pill_setting = pick_set();
      cyc($urandom_range(0, 24) == 0,
          $urandom_range(0, 24) == 0,
          $urandom_range(0, 99) == 0);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
